// File: rtl/lvds_ldi_pkg.sv
// Shared types and section-boundary helpers for the LVDS LDI timing generator.
package lvds_ldi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Sections per axis are ordered active, front porch, sync, back porch.
  function automatic logic [15:0] sync_start(input logic [15:0] active,
                                             input logic [15:0] fp);
    return active + fp;
  endfunction

  function automatic logic [15:0] sync_end(input logic [15:0] active,
                                           input logic [15:0] fp,
                                           input logic [15:0] sync);
    return active + fp + sync;
  endfunction

  function automatic logic [15:0] axis_total(input logic [15:0] active,
                                             input logic [15:0] fp,
                                             input logic [15:0] sync,
                                             input logic [15:0] bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lvds_ldi_timing_gen_if.sv
// Video timing bundle between the generator and a pixel consumer.
interface lvds_ldi_timing_gen_if;

  logic        enable;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pix_req;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        frame_start;
  logic        running;

  modport master (
    input  enable,
    output hsync,
    output vsync,
    output de,
    output pix_req,
    output pix_x,
    output pix_y,
    output frame_start,
    output running
  );

  modport slave (
    output enable,
    input  hsync,
    input  vsync,
    input  de,
    input  pix_req,
    input  pix_x,
    input  pix_y,
    input  frame_start,
    input  running
  );

endinterface

// File: rtl/lvds_ldi_axis_cnt.sv
// One timing axis: wrapping position counter with active-region and sync-region decode.
module lvds_ldi_axis_cnt
  import lvds_ldi_pkg::*;
#(
  parameter logic [15:0] ACTIVE = 16'd1024,
  parameter logic [15:0] FP     = 16'd24,
  parameter logic [15:0] SYNC   = 16'd136,
  parameter logic [15:0] BP     = 16'd160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o,
  output logic        last_o,
  output logic        active_o,
  output logic        sync_o
);

  localparam logic [15:0] TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [15:0] SYNC_START = sync_start(ACTIVE, FP);
  localparam logic [15:0] SYNC_END   = sync_end(ACTIVE, FP, SYNC);

  // An empty section would collapse boundaries and break the sync/active decode.
  if (ACTIVE == 16'd0 || FP == 16'd0 || SYNC == 16'd0 || BP == 16'd0) begin : g_param_err
    $error("lvds_ldi_axis_cnt: every section width must be non-zero");
  end

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign last_o   = (cnt_q == TOTAL - 16'd1);
  assign active_o = (cnt_q < ACTIVE);
  assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lvds_ldi_timing_gen.sv
// LVDS LDI display timing generator: IDLE/RUN/DRAIN control, H/V counters,
// one-ahead pixel request and registered de/hsync/vsync/frame_start.
module lvds_ldi_timing_gen
  import lvds_ldi_pkg::*;
#(
  parameter logic [15:0] H_ACTIVE = 16'd1024,
  parameter logic [15:0] H_FP     = 16'd24,
  parameter logic [15:0] H_SYNC   = 16'd136,
  parameter logic [15:0] H_BP     = 16'd160,
  parameter logic [15:0] V_ACTIVE = 16'd768,
  parameter logic [15:0] V_FP     = 16'd3,
  parameter logic [15:0] V_SYNC   = 16'd6,
  parameter logic [15:0] V_BP     = 16'd29,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  lvds_ldi_timing_gen_if.master         vid
);

  state_e      state_q;
  state_e      state_d;

  logic        run;
  logic        cnt_clr;
  logic        h_inc;
  logic        v_inc;
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        h_act;
  logic        v_act;
  logic        h_sync;
  logic        v_sync;
  logic        pix_req;

  logic        de_q;
  logic        de_d;
  logic        hsync_q;
  logic        hsync_d;
  logic        vsync_q;
  logic        vsync_d;
  logic        fs_q;
  logic        fs_d;

  assign run = (state_q != ST_IDLE);

  // Counters only move once RUN is entered, so the first RUN clock sits at h=0, v=0.
  assign cnt_clr = (state_d == ST_IDLE);
  assign h_inc   = run;
  assign v_inc   = run & h_last;

  lvds_ldi_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (cnt_clr),
    .inc_i    (h_inc),
    .cnt_o    (h_cnt),
    .last_o   (h_last),
    .active_o (h_act),
    .sync_o   (h_sync)
  );

  lvds_ldi_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (cnt_clr),
    .inc_i    (v_inc),
    .cnt_o    (v_cnt),
    .last_o   (v_last),
    .active_o (v_act),
    .sync_o   (v_sync)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vid.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!vid.enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vid.enable) begin
          state_d = ST_RUN;
        end else if (h_last && v_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pix_req = run & h_act & v_act;

  // Registered outputs lag the counters by one clock, giving de = pix_req delayed by one.
  always_comb begin
    de_d    = pix_req;
    hsync_d = (run && h_sync) ? HS_POL : ~HS_POL;
    vsync_d = (run && v_sync) ? VS_POL : ~VS_POL;
    fs_d    = run && (h_cnt == 16'd0) && (v_cnt == 16'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign vid.pix_req     = pix_req;
  assign vid.pix_x       = pix_req ? h_cnt : 16'd0;
  assign vid.pix_y       = pix_req ? v_cnt : 16'd0;
  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.frame_start = fs_q;
  assign vid.running     = run;

endmodule

// File: tb/tb_lvds_ldi_timing_gen.sv
// Directed bench for lvds_ldi_timing_gen with H=8/2/2/2, V=4/1/1/1, hsync active-high, vsync active-low.
module tb_lvds_ldi_timing_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lvds_ldi_timing_gen_if vid();

  lvds_ldi_timing_gen #(
    .H_ACTIVE (16'd8),
    .H_FP     (16'd2),
    .H_SYNC   (16'd2),
    .H_BP     (16'd2),
    .V_ACTIVE (16'd4),
    .V_FP     (16'd1),
    .V_SYNC   (16'd1),
    .V_BP     (16'd1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int rst; int en;
    int run; int req; int x; int y; int de; int hs; int vs; int fs;
  } vec_t;

  vec_t vecs[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int idle_bad();
    return int'(vid.running !== 1'b0) + int'(vid.pix_req !== 1'b0) +
           int'(vid.pix_x !== 16'd0) + int'(vid.pix_y !== 16'd0) +
           int'(vid.de !== 1'b0) + int'(vid.frame_start !== 1'b0) +
           int'(vid.hsync !== 1'b0) + int'(vid.vsync !== 1'b1);
  endfunction

  task automatic wait_fs(input string name, input int bound);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < bound) begin
      step();
      n++;
      if (vid.frame_start === 1'b1) found = 1'b1;
    end
    check(name, int'(found), 1);
  endtask

  // Entered on a frame_start sample (k=0); registered outputs reflect counter k,
  // pix_* reflect counter k+1. Leaves on the next frame_start sample.
  task automatic check_steady_frame();
    int e_de, e_hs, e_vs, e_fs, e_req, e_pix, n_de, n_hs, n_vs;
    int eh, ev, c, ch, cv, er;
    e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_req = 0; e_pix = 0;
    n_de = 0; n_hs = 0; n_vs = 0;
    for (int k = 0; k < 98; k++) begin
      eh = k % 14;
      ev = k / 14;
      c  = (k + 1) % 98;
      ch = c % 14;
      cv = c / 14;
      er = (ch < 8 && cv < 4) ? 1 : 0;
      if (int'(vid.de) != ((eh < 8 && ev < 4) ? 1 : 0)) e_de++;
      if (int'(vid.hsync) != ((eh == 10 || eh == 11) ? 1 : 0)) e_hs++;
      if (int'(vid.vsync) != ((ev == 5) ? 0 : 1)) e_vs++;
      if (int'(vid.frame_start) != ((k == 0) ? 1 : 0)) e_fs++;
      if (int'(vid.pix_req) != er) e_req++;
      if (int'(vid.pix_x) != (er != 0 ? ch : 0) || int'(vid.pix_y) != (er != 0 ? cv : 0)) e_pix++;
      n_de += int'(vid.de);
      n_hs += int'(vid.hsync);
      n_vs += int'(!vid.vsync);
      step();
    end
    check("frame_period_98", int'(vid.frame_start), 1);
    check("de_position_errs", e_de, 0);
    check("hsync_position_errs", e_hs, 0);
    check("vsync_position_errs", e_vs, 0);
    check("frame_start_errs", e_fs, 0);
    check("pix_req_errs", e_req, 0);
    check("pix_xy_errs", e_pix, 0);
    check("de_per_frame", n_de, 32);
    check("hsync_clocks", n_hs, 14);
    check("vsync_clocks", n_vs, 14);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_de, err, bad;
    bit found;

    //            rst en run req x y de hs vs fs
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
    vecs[5]  = '{0, 1, 1, 1, 2, 0, 1, 0, 1, 0};
    vecs[6]  = '{0, 1, 1, 1, 3, 0, 1, 0, 1, 0};
    vecs[7]  = '{0, 1, 1, 1, 4, 0, 1, 0, 1, 0};
    vecs[8]  = '{0, 1, 1, 1, 5, 0, 1, 0, 1, 0};
    vecs[9]  = '{0, 1, 1, 1, 6, 0, 1, 0, 1, 0};
    vecs[10] = '{0, 1, 1, 1, 7, 0, 1, 0, 1, 0};
    vecs[11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0};
    vecs[12] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[14] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[15] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[16] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vecs[17] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 0};
    vecs[18] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 0};

    reset = 1'b1;
    vid.enable = 1'b0;

    for (int i = 0; i < 19; i++) begin
      reset      = (vecs[i].rst != 0);
      vid.enable = (vecs[i].en != 0);
      step();
      checks++;
      if (int'(vid.running) != vecs[i].run || int'(vid.pix_req) != vecs[i].req ||
          int'(vid.pix_x) != vecs[i].x || int'(vid.pix_y) != vecs[i].y ||
          int'(vid.de) != vecs[i].de || int'(vid.hsync) != vecs[i].hs ||
          int'(vid.vsync) != vecs[i].vs || int'(vid.frame_start) != vecs[i].fs) begin
        failures++;
        $display("FAIL vec%0d actual run=%0d req=%0d x=%0d y=%0d de=%0d hs=%0d vs=%0d fs=%0d required run=%0d req=%0d x=%0d y=%0d de=%0d hs=%0d vs=%0d fs=%0d",
                 i, vid.running, vid.pix_req, vid.pix_x, vid.pix_y, vid.de, vid.hsync,
                 vid.vsync, vid.frame_start, vecs[i].run, vecs[i].req, vecs[i].x,
                 vecs[i].y, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs);
      end
    end

    // Steady-state frame with enable held high
    wait_fs("steady_fs_found", 200);
    check_steady_frame();

    // Drain: enable dropped on line 2, frame must complete then go idle
    n_de = 0;
    for (int k = 0; k < 97; k++) begin
      if (k == 30) vid.enable = 1'b0;
      n_de += int'(vid.de);
      if (k == 96) check("running_last_clock", int'(vid.running), 1);
      step();
    end
    check("running_after_drain", int'(vid.running), 0);
    check("drain_de_count", n_de, 32);
    err = 0;
    for (int k = 0; k < 30; k++) begin
      err += idle_bad();
      step();
    end
    check("idle_quiet_after_drain", err, 0);

    // Re-enable inside DRAIN: no gap in the frame cadence
    vid.enable = 1'b1;
    wait_fs("reenable_fs_found", 10);
    n = 0;
    n_de = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      if (n == 20) vid.enable = 1'b0;
      if (n == 40) vid.enable = 1'b1;
      n_de += int'(vid.de);
      step();
      n++;
      if (vid.frame_start === 1'b1) found = 1'b1;
    end
    check("reenable_period", n, 98);
    check("reenable_de_count", n_de, 32);

    // Mid-frame asynchronous reset on line 3
    for (int k = 0; k < 45; k++) step();
    check("pre_reset_pix_y", int'(vid.pix_y), 3);
    check("pre_reset_pix_x", int'(vid.pix_x), 4);
    #2;
    reset = 1'b1;
    #1;
    check("reset_immediate", idle_bad(), 0);
    step();
    check("reset_held", idle_bad(), 0);
    reset = 1'b0;
    step();
    bad = int'(vid.running !== 1'b1) + int'(vid.pix_req !== 1'b1) +
          int'(vid.pix_x !== 16'd0) + int'(vid.pix_y !== 16'd0) +
          int'(vid.frame_start !== 1'b0);
    check("post_reset_first_run", bad, 0);
    step();
    check("post_reset_fs", int'(vid.frame_start), 1);
    check("post_reset_pix_x", int'(vid.pix_x), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_ldi_timing_gen.md
LVDS_LDI_TIMING_GEN -- requirements
Module: lvds_ldi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 16'd1024, meaning active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16'd24, meaning horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 16'd136, meaning hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 16'd160, meaning horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 16'd768, meaning active lines per frame.
REQ-006 SHALL have parameter V_FP, default 16'd3, meaning vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 16'd6, meaning vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 16'd29, meaning vertical back porch in lines.
REQ-009 SHALL have parameters HS_POL and VS_POL, default 1'b0, where 1 means the sync is active-high.
REQ-010 SHALL have port clk, input, 1, pixel clock; the block uses one clock.
REQ-011 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-012 SHALL have port enable, input, 1, which requests frame generation.
REQ-013 SHALL have port hsync, output, 1, horizontal sync at HS_POL polarity.
REQ-014 SHALL have port vsync, output, 1, vertical sync at VS_POL polarity.
REQ-015 SHALL have port de, output, 1, data enable.
REQ-016 SHALL have port pix_req, output, 1, pixel fetch request, one clock ahead of de.
REQ-017 SHALL have port pix_x, output, 16, column of the pixel requested by pix_req.
REQ-018 SHALL have port pix_y, output, 16, row of the pixel requested by pix_req.
REQ-019 SHALL have port frame_start, output, 1, one-clock pulse at h=0, v=0 of each frame.
REQ-020 SHALL have port running, output, 1, high while in RUN or DRAIN.

Function
REQ-021 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, order per line: active, FP, sync, BP; V_TOTAL likewise in lines.
REQ-022 SHALL use h_cnt 0..H_TOTAL-1, wrapping to 0 and incrementing v_cnt; v_cnt wraps from V_TOTAL-1 to 0.
REQ-023 SHALL use the state machine IDLE -> RUN on enable=1, RUN -> DRAIN on enable=0, DRAIN -> IDLE on the last clock of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), and DRAIN -> RUN on enable=1 without a counter discontinuity.
REQ-024 SHALL hold h_cnt=v_cnt=0 in IDLE, hold pix_req, de and frame_start low, and hold the syncs inactive.
REQ-025 SHALL assert pix_req combinationally from the counters when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, with pix_x=h_cnt and pix_y=v_cnt; pix_x/pix_y are 0 otherwise.
REQ-026 SHALL register de, hsync, vsync and frame_start, so that de equals pix_req delayed by exactly 1 clock.
REQ-027 SHALL make hsync active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-028 SHALL make vsync active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, with edges aligned to h_cnt=0.
REQ-029 SHALL make the first RUN cycle after IDLE h_cnt=0, v_cnt=0, with frame_start high one clock later.
REQ-030 SHALL generate a full frame in DRAIN and emit no partial frames.
REQ-031 SHALL handle zero-width porches correctly; any section width of 0 is a parameter error and is rejected at elaboration.

Reset
REQ-032 SHALL, on reset=1, immediately force state=IDLE, counters=0, de=pix_req=frame_start=running=0, pix_x=pix_y=0, hsync=~HS_POL and vsync=~VS_POL.
REQ-033 SHALL apply reset mid-frame as an immediate abort, restarting from v=0 after release when enable=1.

Structure
REQ-034 SHALL place the state enum (IDLE, RUN, DRAIN) and the section-boundary constant functions in package lvds_ldi_pkg.
REQ-035 SHALL use one sub-module lvds_ldi_axis_cnt (counter + active/sync decode), instantiated for the H and V axes.

Verification
REQ-036 SHALL run the bench with H=8/2/2/2 and V=4/1/1/1 (H_TOTAL=14, V_TOTAL=7); the frame SHALL be 98 clocks between frame_start pulses.
REQ-037 SHALL check active counts: enable held high -> 32 de clocks per frame, de runs of 8, pix_x 0..7 one clock before de.
REQ-038 SHALL check sync positions: hsync active at h=10,11 (2 clocks/line), vsync active for lines 5 (14 clocks), edges at h=0.
REQ-039 SHALL check drain: enable dropped at v=2 -> frame completes, running falls after h=13, v=6, then IDLE.
REQ-040 SHALL check re-enable during DRAIN: enable 0 then 1 within one frame -> no gap, next frame_start exactly 98 clocks later.
REQ-041 SHALL check mid-frame reset: reset pulse at v=3 -> outputs inactive the same cycle, frame_start 1 clock after the first post-reset RUN cycle.
